// File: rtl/gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if
//
// Control/status bundle for the switching-activity generator.
//   EN     run request (level)
//   DUTY   active cycles per period, sampled at period start (PW bits)
//   CLR    synchronous clear of the active-cycle counter
//   Q      16-bit toggle bank
//   BUSY   generator is inside a period (running or draining)
//   PDONE  one-cycle pulse after the edge that completes a period
//   TCNT   saturating count of active cycles (CW bits)
// Modports: master drives the controls, slave is the generator.
// -----------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if #(
   parameter int PW = 8,
   parameter int CW = 16
);
   logic          EN;
   logic [PW-1:0] DUTY;
   logic          CLR;
   logic [15:0]   Q;
   logic          BUSY;
   logic          PDONE;
   logic [CW-1:0] TCNT;

   modport master (
      output EN, DUTY, CLR,
      input  Q, BUSY, PDONE, TCNT
   );

   modport slave (
      input  EN, DUTY, CLR,
      output Q, BUSY, PDONE, TCNT
   );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__toggle_gen.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__toggle_gen
//
// Duty-cycled switching-activity aggressor for power-integrity tiles. A period
// is 2^PW clock edges; the first DUTY_L edges of a period are "active" and
// update the 16-bit bank Q, the rest hold it. TCNT counts active edges and
// saturates. Dropping EN mid-period lets the current period drain to its end.
//
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-high reset
//   bus   slave modport of gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if
//         (EN, DUTY, CLR in; Q, BUSY, PDONE, TCNT out, all registered)
//
// Build option:
//   LFSR_EN  defined   : active edges load Q with the next state of a 16-bit
//                        Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1)
//            undefined : active edges invert Q; the pattern register idles
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__toggle_gen #(
   parameter int PW = 8,
   parameter int CW = 16
) (
   input logic CLK,
   input logic RST,
   gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [PW-1:0] PCNT_LAST = {PW{1'b1}};
   localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PCNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] TCNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] TCNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] TCNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [15:0]   LFSR_SEED = 16'hACE1;

`ifdef LFSR_EN
   // Shift-left Fibonacci step; taps 16,14,13,11 map to bits 15,13,12,10.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction
`endif

   state_t        state_r, state_s;
   logic [PW-1:0] pcnt_r, pcnt_s;
   logic [PW-1:0] duty_l_r, duty_l_s;
   logic [15:0]   pattern_r, pattern_s;
   logic [15:0]   q_r, q_s;
   logic [CW-1:0] tcnt_r, tcnt_s, tcnt_inc_s;
   logic          busy_r, busy_s;
   logic          pdone_r, pdone_s;
   logic          period_last_s;
   logic          active_s;

   // Period sequencing: next state, period counter, latched duty, PDONE.
   always_comb begin
      state_s       = state_r;
      pcnt_s        = pcnt_r;
      duty_l_s      = duty_l_r;
      pdone_s       = 1'b0;
      active_s      = 1'b0;
      period_last_s = (pcnt_r == PCNT_LAST);
      case (state_r)
         ST_IDLE: begin
            if (bus.EN) begin
               state_s  = ST_RUN;
               pcnt_s   = PCNT_ZERO;
               duty_l_s = bus.DUTY;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            active_s = (pcnt_r < duty_l_r);
            pcnt_s   = pcnt_r + PCNT_ONE;   // wraps to zero after the last edge
            pdone_s  = period_last_s;
            if (period_last_s) begin
               if (bus.EN) begin
                  state_s  = ST_RUN;
                  duty_l_s = bus.DUTY;
               end else begin
                  state_s  = ST_IDLE;
                  pcnt_s   = PCNT_ZERO;
               end
            end else if (!bus.EN) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // EN is deliberately ignored until the period is over.
            active_s = (pcnt_r < duty_l_r);
            pcnt_s   = pcnt_r + PCNT_ONE;
            pdone_s  = period_last_s;
            if (period_last_s) begin
               state_s = ST_IDLE;
               pcnt_s  = PCNT_ZERO;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            pcnt_s  = PCNT_ZERO;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // Toggle bank, pattern generator and active-cycle counter updates.
   always_comb begin
      q_s        = q_r;
      pattern_s  = pattern_r;
      tcnt_inc_s = tcnt_r;
      if (active_s) begin
`ifdef LFSR_EN
         pattern_s = lfsr_next(pattern_r);
         q_s       = lfsr_next(pattern_r);
`else
         q_s       = ~q_r;
`endif
         if (tcnt_r != TCNT_MAX) begin
            tcnt_inc_s = tcnt_r + TCNT_ONE;
         end else begin
            tcnt_inc_s = tcnt_r;
         end
      end else begin
         q_s        = q_r;
         tcnt_inc_s = tcnt_r;
      end
      // Clear wins over a same-edge increment.
      tcnt_s = bus.CLR ? TCNT_ZERO : tcnt_inc_s;
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r   <= ST_IDLE;
         pcnt_r    <= PCNT_ZERO;
         duty_l_r  <= PCNT_ZERO;
         pattern_r <= LFSR_SEED;
         q_r       <= 16'h0000;
         tcnt_r    <= TCNT_ZERO;
         busy_r    <= 1'b0;
         pdone_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         pcnt_r    <= pcnt_s;
         duty_l_r  <= duty_l_s;
         pattern_r <= pattern_s;
         q_r       <= q_s;
         tcnt_r    <= tcnt_s;
         busy_r    <= busy_s;
         pdone_r   <= pdone_s;
      end
   end

   assign bus.Q     = q_r;
   assign bus.BUSY  = busy_r;
   assign bus.PDONE = pdone_r;
   assign bus.TCNT  = tcnt_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__toggle_gen.sv
// -----------------------------------------------------------------------------
// Bench for gf180mcu_fd_sc_mcu7t5v0__toggle_gen. Two instances: A (PW=8,
// CW=16) and B (PW=4, CW=4, for counter saturation). Each has a behavioural
// period model compared every cycle, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__toggle_gen;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if #(.PW(8), .CW(16)) bus_a ();
   gf180mcu_fd_sc_mcu7t5v0__toggle_gen_if #(.PW(4), .CW(4))  bus_b ();

   gf180mcu_fd_sc_mcu7t5v0__toggle_gen #(.PW(8), .CW(16)) dut_a (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_a)
   );

   gf180mcu_fd_sc_mcu7t5v0__toggle_gen #(.PW(4), .CW(4)) dut_b (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_b)
   );

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;
   bit a_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wn(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          in_period;
      bit          keep;       // EN has stayed high since the period began
      int          pcnt;
      int          duty_l;
      logic [15:0] q;
      logic [15:0] pat;
      int          tcnt;
      bit          pdone;
   } mdl_t;

   function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.in_period = 1'b0; m.keep = 1'b0; m.pcnt = 0; m.duty_l = 0;
      m.q = 16'h0000; m.pat = 16'hACE1; m.tcnt = 0; m.pdone = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input int pw, input int cw,
                                     input bit en, input int duty, input bit clr);
      mdl_t n;
      int   plen;
      int   tmax;
      n     = m;
      n.pdone = 1'b0;
      plen  = 1 << pw;
      tmax  = (1 << cw) - 1;
      if (!m.in_period) begin
         if (en) begin
            n.in_period = 1'b1; n.keep = 1'b1; n.pcnt = 0; n.duty_l = duty;
         end
      end else begin
         if (m.pcnt < m.duty_l) begin
`ifdef LFSR_EN
            n.pat = ref_lfsr(m.pat);
            n.q   = n.pat;
`else
            n.q   = ~m.q;
`endif
            if (m.tcnt < tmax) n.tcnt = m.tcnt + 1;
         end
         n.pcnt = (m.pcnt + 1) % plen;
         if (m.pcnt == plen - 1) begin
            n.pdone = 1'b1;
            if (m.keep && en) begin
               n.duty_l = duty;
               n.keep   = 1'b1;
            end else begin
               n.in_period = 1'b0;
               n.pcnt      = 0;
            end
         end else begin
            n.keep = m.keep && en;
         end
      end
      if (clr) n.tcnt = 0;
      return n;
   endfunction

   mdl_t ma, mb;

   always @(posedge CLK or posedge RST) begin
      if (RST) ma <= mdl_reset();
      else     ma <= mdl_step(ma, 8, 16, bus_a.EN === 1'b1, int'(bus_a.DUTY), bus_a.CLR === 1'b1);
   end

   always @(posedge CLK or posedge RST) begin
      if (RST) mb <= mdl_reset();
      else     mb <= mdl_step(mb, 4, 4, bus_b.EN === 1'b1, int'(bus_b.DUTY), bus_b.CLR === 1'b1);
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (chk_on && !RST) begin
         chk("A.Q",     32'(bus_a.Q),     32'(ma.q));
         chk("A.BUSY",  32'(bus_a.BUSY),  32'(ma.in_period));
         chk("A.PDONE", 32'(bus_a.PDONE), 32'(ma.pdone));
         chk("A.TCNT",  32'(bus_a.TCNT),  32'(ma.tcnt));
         chk("B.Q",     32'(bus_b.Q),     32'(mb.q));
         chk("B.BUSY",  32'(bus_b.BUSY),  32'(mb.in_period));
         chk("B.PDONE", 32'(bus_b.PDONE), 32'(mb.pdone));
         chk("B.TCNT",  32'(bus_b.TCNT),  32'(mb.tcnt));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] q_hold;
      int pulses;
      int busy_low;

      bus_a.EN = 1'b0; bus_a.DUTY = 8'd0; bus_a.CLR = 1'b0;
      bus_b.EN = 1'b0; bus_b.DUTY = 4'd0; bus_b.CLR = 1'b0;
      RST = 1'b1;
      wn(3);
      RST = 1'b0;
      chk_on = 1'b1;
      chk("rst_A.Q",     32'(bus_a.Q),     32'h0000);
      chk("rst_A.BUSY",  32'(bus_a.BUSY),  32'd0);
      chk("rst_A.PDONE", 32'(bus_a.PDONE), 32'd0);
      chk("rst_A.TCNT",  32'(bus_a.TCNT),  32'd0);
      chk("rst_B.TCNT",  32'(bus_b.TCNT),  32'd0);

      fork
         begin : branch_a
            // Test 1: DUTY=4, one period.
            bus_a.EN = 1'b1; bus_a.DUTY = 8'd4;
            wn(1);
            chk("t1_busy_k", 32'(bus_a.BUSY), 32'd1);
            chk("t1_q_k",    32'(bus_a.Q),    32'h0000);
            chk("t1_tcnt_k", 32'(bus_a.TCNT), 32'd0);
            wn(1);
`ifdef LFSR_EN
            chk("t1_q_e0", 32'(bus_a.Q), 32'h59C3);
`else
            chk("t1_q_e0", 32'(bus_a.Q), 32'hFFFF);
`endif
            chk("t1_tcnt_e0", 32'(bus_a.TCNT), 32'd1);
            wn(3);
`ifndef LFSR_EN
            chk("t1_q_e3", 32'(bus_a.Q), 32'h0000);
`endif
            chk("t1_tcnt_e3", 32'(bus_a.TCNT), 32'd4);
            wn(251);
            chk("t1_pdone_e254", 32'(bus_a.PDONE), 32'd0);
            bus_a.DUTY = 8'd0;
            wn(1);
            chk("t1_pdone_e255", 32'(bus_a.PDONE), 32'd1);
            chk("t1_tcnt_end",   32'(bus_a.TCNT),  32'd4);

            // Test 2: DUTY=0 for three periods.
            pulses = 0; busy_low = 0;
            for (int i = 0; i < 767; i++) begin
               wn(1);
               if (bus_a.PDONE) pulses++;
               if (!bus_a.BUSY) busy_low++;
            end
            bus_a.DUTY = 8'd255; bus_a.CLR = 1'b1;
            wn(1);
            if (bus_a.PDONE) pulses++;
            bus_a.CLR = 1'b0;
            chk("t2_pulses",   32'(pulses),       32'd3);
            chk("t2_busy_low", 32'(busy_low),     32'd0);
            chk("t2_tcnt_clr", 32'(bus_a.TCNT),   32'd0);
`ifndef LFSR_EN
            chk("t2_q_hold",   32'(bus_a.Q),      32'h0000);
`endif

            // Test 3: DUTY=255, EN dropped at PCNT=10, period drains.
            wn(10);
            bus_a.EN = 1'b0;
            wn(1);
            chk("t3_busy_drain", 32'(bus_a.BUSY), 32'd1);
            wn(90);
            bus_a.EN = 1'b1;
            wn(154);
            chk("t3_busy_e254",  32'(bus_a.BUSY),  32'd1);
            chk("t3_pdone_e254", 32'(bus_a.PDONE), 32'd0);
            wn(1);
            chk("t3_pdone_end",  32'(bus_a.PDONE), 32'd1);
            chk("t3_busy_end",   32'(bus_a.BUSY),  32'd0);
            chk("t3_tcnt_end",   32'(bus_a.TCNT),  32'd255);
`ifndef LFSR_EN
            chk("t3_q_end",      32'(bus_a.Q),     32'hFFFF);
`endif
            bus_a.EN = 1'b0;
            wn(1);
            chk("t3_busy_idle",  32'(bus_a.BUSY),  32'd0);
            chk("t3_pdone_idle", 32'(bus_a.PDONE), 32'd0);

            // Test 4: fresh reset, DUTY=2, mid-period DUTY change ignored.
            RST = 1'b1;
            wn(2);
            RST = 1'b0;
            bus_a.EN = 1'b1; bus_a.DUTY = 8'd2;
            wn(1);
            chk("t4_q_k", 32'(bus_a.Q), 32'h0000);
            wn(1);
`ifdef LFSR_EN
            chk("t4_q_e0", 32'(bus_a.Q), 32'h59C3);
`else
            chk("t4_q_e0", 32'(bus_a.Q), 32'hFFFF);
`endif
            wn(1);
`ifdef LFSR_EN
            chk("t4_q_e1", 32'(bus_a.Q), 32'hB387);
`else
            chk("t4_q_e1", 32'(bus_a.Q), 32'h0000);
`endif
            chk("t4_tcnt_e1", 32'(bus_a.TCNT), 32'd2);
            q_hold = bus_a.Q;
            wn(4);
            bus_a.DUTY = 8'd200;
            wn(94);
            chk("t4_q_hold",    32'(bus_a.Q),     32'(q_hold));
            chk("t4_tcnt_hold", 32'(bus_a.TCNT),  32'd2);

            // Test 5: asynchronous reset at PCNT=100.
            #2 RST = 1'b1;
            #1;
            chk("t5_q_async",     32'(bus_a.Q),     32'h0000);
            chk("t5_busy_async",  32'(bus_a.BUSY),  32'd0);
            chk("t5_pdone_async", 32'(bus_a.PDONE), 32'd0);
            chk("t5_tcnt_async",  32'(bus_a.TCNT),  32'd0);
            wn(1);
            chk("t5_pdone_hold",  32'(bus_a.PDONE), 32'd0);
            RST = 1'b0;
            bus_a.EN = 1'b0;

            // Randomised phase against the model.
            for (int i = 0; i < 4000; i++) begin
               wn(1);
               if ($urandom_range(0, 63) == 0) bus_a.EN = ~bus_a.EN;
               if ($urandom_range(0, 31) == 0) begin
                  case ($urandom_range(0, 3))
                     0:       bus_a.DUTY = 8'd0;
                     1:       bus_a.DUTY = 8'd255;
                     default: bus_a.DUTY = 8'($urandom_range(0, 255));
                  endcase
               end
               bus_a.CLR = ($urandom_range(0, 99) == 0);
            end
            bus_a.CLR = 1'b0;
            a_done = 1'b1;
         end
         begin : branch_b
            // Saturation at 15, then clear on an active edge.
            bus_b.EN = 1'b1; bus_b.DUTY = 4'd15;
            wn(40);
            chk("b_tcnt_sat", 32'(bus_b.TCNT), 32'd15);
            bus_b.CLR = 1'b1;
            wn(1);
            chk("b_tcnt_clr", 32'(bus_b.TCNT), 32'd0);
            bus_b.CLR = 1'b0;
            wn(1);
            chk("b_tcnt_after_clr", 32'(bus_b.TCNT), 32'd1);
            while (!a_done) begin
               wn(1);
               if ($urandom_range(0, 15) == 0) bus_b.EN = ~bus_b.EN;
               if ($urandom_range(0, 7) == 0) bus_b.DUTY = 4'($urandom_range(0, 15));
               bus_b.CLR = ($urandom_range(0, 49) == 0);
            end
            bus_b.CLR = 1'b0;
         end
      join

      wn(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__toggle_gen.md
# gf180mcu_fd_sc_mcu7t5v0__toggle_gen

Programmable switching-activity generator for the mcu7t5v0 library's power-integrity characterization tiles. It drives a 16-bit register bank with a duty-cycled toggle pattern, creating controlled supply current draw. Passive fill/decap cells in the same tile absorb that current. The block is the active aggressor placed next to decap fill in characterization rows, and reports how many active cycles it has produced.

## Interface
- PW, 8, period-counter width; one period = 2^PW cycles
- CW, 16, width of the active-cycle counter TCNT
- CLK  input  1  rising-edge clock
- RST  input  1  reset, asynchronous and active-high
- EN  input  1  run request; level-sensitive
- DUTY  input  PW  number of active (toggling) cycles per period, sampled at period start
- CLR  input  1  synchronous clear of TCNT
- Q  output  16  toggle bank
- BUSY  output  1  high in RUN or DRAIN
- PDONE  output  1  one-cycle pulse on the edge that completes a period
- TCNT  output  CW  saturating count of active cycles

## Operation
- States:
  - IDLE: BUSY=0. Q, PCNT and the pattern register hold. TCNT holds unless CLR is high.
  - RUN: the period is running and EN is still requested.
  - DRAIN: EN has dropped; the current period is finishing.
- Transitions:
  - IDLE -> RUN on an edge with EN=1. At that edge: DUTY_L <= DUTY and PCNT <= 0.
  - RUN -> DRAIN on an edge with EN=0 and PCNT != 2^PW-1.
  - RUN at PCNT == 2^PW-1:
    - EN=1: stay in RUN, PCNT wraps to 0, DUTY_L <= DUTY.
    - EN=0: go to IDLE, PCNT <= 0.
  - DRAIN ignores EN. At PCNT == 2^PW-1 it goes to IDLE and PCNT <= 0.
- Per edge in RUN/DRAIN:
  - The edge is active when PCNT < DUTY_L.
  - On an active edge, Q takes the next pattern and TCNT increments, saturating at 2^CW-1.
  - On a quiet edge, Q holds.
  - PCNT increments on every edge, modulo 2^PW.
- PDONE=1 for the cycle after any edge where PCNT was 2^PW-1 in RUN/DRAIN; it is 0 otherwise.
- DUTY limits:
  - DUTY_L=0: no active edges.
  - DUTY_L=2^PW-1: 2^PW-1 active edges and one quiet edge per period.
- DUTY changes mid-period have no effect until the next period start.
- CLR applies in any state. If CLR and an increment occur on the same edge, TCNT=0 (clear wins).

## Timing
- Reset values: Q=16'h0000, BUSY=0, PDONE=0, TCNT=0, state IDLE, PCNT=0, DUTY_L=0, pattern register 16'hACE1.
- Asserting RST mid-period returns all of the above immediately, with no drain.
- EN sampled high at edge k: BUSY=1 after edge k. The first active Q update is at edge k+1 when DUTY>0.
- Period length from the first RUN edge to the PDONE edge is exactly 2^PW edges.
- TCNT reflects an active edge in the same cycle Q changes; there is no pipeline latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro LFSR_EN defined:
  - An active edge loads Q with the next state of a 16-bit Fibonacci LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0, seed 16'hACE1.
  - The LFSR advances only on active edges.
- Macro LFSR_EN undefined:
  - An active edge sets Q <= ~Q, giving maximum activity with all bits toggling.
  - The pattern register is unused.

## Test plan
- Reset, then EN=1 with DUTY=4, PW=8, LFSR_EN off:
  - Q alternates FFFF/0000 on edges k+1..k+4, then holds for 252 edges.
  - PDONE pulses after edge k+256; TCNT=4.
- DUTY=0 for 3 periods: Q stays 0000, TCNT=0, PDONE pulses 3 times, BUSY=1 throughout.
- EN dropped at PCNT=10 with DUTY=255: state goes to DRAIN and the period completes. Then:
  - TCNT=255 and PDONE pulses once.
  - BUSY=0 after the period-end edge; re-asserting EN during DRAIN does not extend it.
- LFSR_EN on, DUTY=2: Q=0xACE1-successor, then its successor. Q then holds until the next period.
- CW=4, continuous run: TCNT saturates at 15. CLR asserted on an active edge gives TCNT=0 after that edge.
- RST asserted mid-period at PCNT=100: all outputs return to reset values asynchronously, with no PDONE.
